// File: rtl/band_serializer.sv
// band_serializer: two-slot frame buffer that streams the enabled
// bands of each captured 8-band frame one word per valid/ready beat.
module band_serializer #(
   parameter int DATA_W = 16,
   parameter int NBANDS = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     capture,
   input  logic signed [DATA_W-1:0] band0,
   input  logic signed [DATA_W-1:0] band1,
   input  logic signed [DATA_W-1:0] band2,
   input  logic signed [DATA_W-1:0] band3,
   input  logic signed [DATA_W-1:0] band4,
   input  logic signed [DATA_W-1:0] band5,
   input  logic signed [DATA_W-1:0] band6,
   input  logic signed [DATA_W-1:0] band7,
   input  logic [NBANDS-1:0]        band_mask,
   output logic signed [DATA_W-1:0] dout,
   output logic [2:0]               dout_band,
   output logic                     dout_last,
   output logic                     dout_valid,
   input  logic                     dout_ready,
   output logic [1:0]               frames_pending,
   output logic                     overflow,
   output logic [7:0]               drop_count
);

   typedef enum logic {IDLE, SEND} state_t;

   localparam logic [NBANDS-1:0] ONE = NBANDS'(1);

   state_t            state_q;
   logic [DATA_W-1:0] slot_q [2][NBANDS];
   logic [NBANDS-1:0] rem_q [2];
   logic              wptr_q;
   logic              rptr_q;
   logic [1:0]        count_q;

   logic [DATA_W-1:0] band_in [NBANDS];
   logic              hs;
   logic              pop;
   logic              store;
   logic              drop;
   logic [NBANDS-1:0] cur_rem;
   logic [NBANDS-1:0] adv_rem;
   logic [NBANDS-1:0] oth_rem;
   logic [2:0]        cur_idx;
   logic [2:0]        adv_idx;
   logic [2:0]        oth_idx;

   function automatic logic [2:0] first_idx(input logic [NBANDS-1:0] m);
      first_idx = 3'd0;
      for (int i = NBANDS - 1; i >= 0; i--)
         if (m[i]) first_idx = 3'(i);
   endfunction

   function automatic logic only_one(input logic [NBANDS-1:0] m);
      only_one = (m != '0) && ((m & (m - ONE)) == '0);
   endfunction

   assign band_in[0] = band0;
   assign band_in[1] = band1;
   assign band_in[2] = band2;
   assign band_in[3] = band3;
   assign band_in[4] = band4;
   assign band_in[5] = band5;
   assign band_in[6] = band6;
   assign band_in[7] = band7;

   assign frames_pending = count_q;

   always_comb begin
      hs      = (state_q == SEND) && dout_ready;
      pop     = hs && dout_last;
      store   = capture && (band_mask != '0) && ((count_q != 2'd2) || pop);
      drop    = capture && (band_mask != '0) && (count_q == 2'd2) && !pop;
      cur_rem = rem_q[rptr_q];
      adv_rem = cur_rem & ~(ONE << dout_band);
      oth_rem = rem_q[~rptr_q];
      cur_idx = first_idx(cur_rem);
      adv_idx = first_idx(adv_rem);
      oth_idx = first_idx(oth_rem);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         wptr_q     <= 1'b0;
         rptr_q     <= 1'b0;
         count_q    <= 2'd0;
         dout       <= '0;
         dout_band  <= 3'd0;
         dout_last  <= 1'b0;
         dout_valid <= 1'b0;
         overflow   <= 1'b0;
         drop_count <= 8'd0;
         for (int s = 0; s < 2; s++) begin
            rem_q[s] <= '0;
            for (int k = 0; k < NBANDS; k++) slot_q[s][k] <= '0;
         end
      end else begin
         count_q <= count_q + {1'b0, store} - {1'b0, pop};
         if (drop) begin
            overflow <= 1'b1;
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
         end
         case (state_q)
            IDLE: begin
               if (count_q != 2'd0) begin
                  dout       <= slot_q[rptr_q][cur_idx];
                  dout_band  <= cur_idx;
                  dout_last  <= only_one(cur_rem);
                  dout_valid <= 1'b1;
                  state_q    <= SEND;
               end
            end
            SEND: begin
               if (hs && dout_last) begin
                  rem_q[rptr_q] <= '0;
                  rptr_q        <= ~rptr_q;
                  // Second slot already held: continue with no bubble.
                  if (count_q == 2'd2) begin
                     dout      <= slot_q[~rptr_q][oth_idx];
                     dout_band <= oth_idx;
                     dout_last <= only_one(oth_rem);
                  end else begin
                     dout_valid <= 1'b0;
                     dout_last  <= 1'b0;
                     state_q    <= IDLE;
                  end
               end else if (hs) begin
                  rem_q[rptr_q] <= adv_rem;
                  dout          <= slot_q[rptr_q][adv_idx];
                  dout_band     <= adv_idx;
                  dout_last     <= only_one(adv_rem);
               end
            end
            default: state_q <= IDLE;
         endcase
         // Placed last so a capture into the slot being popped wins.
         if (store) begin
            for (int k = 0; k < NBANDS; k++) slot_q[wptr_q][k] <= band_in[k];
            rem_q[wptr_q] <= band_mask;
            wptr_q        <= ~wptr_q;
         end
      end
   end

endmodule

// File: tb/tb_band_serializer.sv
// Randomized self-checking bench for band_serializer with a
// frame-queue reference model and directed scenario tasks.
module tb_band_serializer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        capture = 1'b0;
   logic [15:0] bv [8];
   logic [7:0]  band_mask = 8'd0;
   logic [15:0] dout;
   logic [2:0]  dout_band;
   logic        dout_last;
   logic        dout_valid;
   logic        dout_ready = 1'b0;
   logic [1:0]  frames_pending;
   logic        overflow;
   logic [7:0]  drop_count;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic [15:0] d;
      logic [2:0]  b;
      logic        l;
   } beat_t;

   beat_t exp_q [$];
   int    m_frames = 0;
   logic  m_ovf = 1'b0;
   int    m_drop = 0;

   always #5 clock = ~clock;

   band_serializer dut (
      .clock(clock), .reset(reset), .capture(capture),
      .band0(bv[0]), .band1(bv[1]), .band2(bv[2]), .band3(bv[3]),
      .band4(bv[4]), .band5(bv[5]), .band6(bv[6]), .band7(bv[7]),
      .band_mask(band_mask), .dout(dout), .dout_band(dout_band),
      .dout_last(dout_last), .dout_valid(dout_valid),
      .dout_ready(dout_ready), .frames_pending(frames_pending),
      .overflow(overflow), .drop_count(drop_count)
   );

   // Reference model: evaluated mid-cycle, predicts the next edge.
   initial begin : scoreboard
      logic        stall_q;
      logic [15:0] s_d;
      logic [2:0]  s_b;
      logic        s_l;
      logic        hs;
      logic        last_pop;
      logic        acc;
      beat_t       f;
      beat_t       nb;
      stall_q = 1'b0;
      s_d = '0; s_b = '0; s_l = 1'b0;
      forever begin
         @(negedge clock);
         checks++;
         if (frames_pending !== 2'(m_frames)) begin
            errors++;
            $display("FAIL sb_pending got %0d exp %0d", frames_pending, m_frames);
         end
         checks++;
         if (overflow !== m_ovf || drop_count !== 8'(m_drop)) begin
            errors++;
            $display("FAIL sb_overflow got %0b/%0d exp %0b/%0d",
                     overflow, drop_count, m_ovf, m_drop);
         end
         if (stall_q) begin
            checks++;
            if (dout !== s_d || dout_band !== s_b || dout_last !== s_l || dout_valid !== 1'b1) begin
               errors++;
               $display("FAIL sb_stall got %h/%0d/%0b exp %h/%0d/%0b",
                        dout, dout_band, dout_last, s_d, s_b, s_l);
            end
         end
         hs = dout_valid && dout_ready;
         if (reset) begin
            exp_q.delete();
            m_frames = 0;
            m_ovf = 1'b0;
            m_drop = 0;
            stall_q = 1'b0;
         end else begin
            last_pop = 1'b0;
            if (hs) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL sb_beat unexpected band %0d data %h", dout_band, dout);
               end else begin
                  f = exp_q.pop_front();
                  last_pop = f.l;
                  if (dout !== f.d || dout_band !== f.b || dout_last !== f.l) begin
                     errors++;
                     $display("FAIL sb_beat got %h/%0d/%0b exp %h/%0d/%0b",
                              dout, dout_band, dout_last, f.d, f.b, f.l);
                  end
               end
            end
            acc = (m_frames < 2) || last_pop;
            if (last_pop) m_frames--;
            if (capture && band_mask != 8'd0) begin
               if (acc) begin
                  m_frames++;
                  for (int k = 0; k < 8; k++)
                     if (band_mask[k]) begin
                        nb.d = bv[k];
                        nb.b = 3'(k);
                        nb.l = ((band_mask >> (k + 1)) == 8'd0);
                        exp_q.push_back(nb);
                     end
               end else begin
                  m_ovf = 1'b1;
                  if (m_drop < 255) m_drop++;
               end
            end
            stall_q = dout_valid && !dout_ready;
            s_d = dout; s_b = dout_band; s_l = dout_last;
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic cap(input logic [7:0] m);
      band_mask = m;
      capture = 1'b1;
      tick();
      capture = 1'b0;
   endtask

   task automatic rand_bands();
      for (int k = 0; k < 8; k++) bv[k] = 16'($urandom);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [15:0] z;
      z = '0;
      rand_bands();
      reset = 1'b1;
      tick();
      tick();
      checks++;
      if (dout !== z || dout_band !== 3'd0 || dout_last !== 1'b0 || dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL reset_out got %h/%0d/%0b/%0b exp 0/0/0/0",
                  dout, dout_band, dout_last, dout_valid);
      end
      checks++;
      if (frames_pending !== 2'd0 || overflow !== 1'b0 || drop_count !== 8'd0) begin
         errors++;
         $display("FAIL reset_status got %0d/%0b/%0d exp 0/0/0",
                  frames_pending, overflow, drop_count);
      end
      reset = 1'b0;
   endtask

   task automatic test_single_frame();
      for (int k = 0; k < 8; k++) bv[k] = 16'h1000 + 16'(k);
      dout_ready = 1'b1;
      cap(8'hFF);
      checks++;
      if (frames_pending !== 2'd1 || dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_latency got pend %0d valid %0b exp 1/0", frames_pending, dout_valid);
      end
      tick();
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (dout_valid !== 1'b1 || dout !== 16'h1000 + 16'(i) ||
             dout_band !== 3'(i) || dout_last !== (i == 7)) begin
            errors++;
            $display("FAIL single_beat%0d got %0b/%h/%0d/%0b exp 1/%h/%0d/%0b",
                     i, dout_valid, dout, dout_band, dout_last, 16'h1000 + 16'(i), i, i == 7);
         end
         tick();
      end
      checks++;
      if (dout_valid !== 1'b0 || frames_pending !== 2'd0) begin
         errors++;
         $display("FAIL single_end got valid %0b pend %0d exp 0/0", dout_valid, frames_pending);
      end
   endtask

   task automatic test_sparse();
      logic [15:0] ed [3];
      logic [2:0]  eb [3];
      ed[0] = 16'hFFFF; ed[1] = 16'hFFFD; ed[2] = 16'hFFF8;
      eb[0] = 3'd0;     eb[1] = 3'd2;     eb[2] = 3'd7;
      for (int k = 0; k < 8; k++) bv[k] = 16'hFFFF - 16'(k);
      dout_ready = 1'b1;
      cap(8'h85);
      tick();
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (dout_valid !== 1'b1 || dout !== ed[i] || dout_band !== eb[i] || dout_last !== (i == 2)) begin
            errors++;
            $display("FAIL sparse_beat%0d got %0b/%h/%0d/%0b exp 1/%h/%0d/%0b",
                     i, dout_valid, dout, dout_band, dout_last, ed[i], eb[i], i == 2);
         end
         tick();
      end
      checks++;
      if (dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL sparse_end got valid %0b exp 0", dout_valid);
      end
      rand_bands();
      cap(8'h00);
      tick();
      tick();
      checks++;
      if (dout_valid !== 1'b0 || frames_pending !== 2'd0 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL zero_mask got %0b/%0d/%0b exp 0/0/0", dout_valid, frames_pending, overflow);
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] saved [8];
      int n;
      rand_bands();
      saved = bv;
      n = 0;
      dout_ready = 1'b0;
      cap(8'hFF);
      for (int i = 0; i < 60 && n < 8; i++) begin
         dout_ready = (i % 3 == 0);
         if (dout_valid && dout_ready) begin
            checks++;
            if (dout_band !== 3'(n) || dout !== saved[n]) begin
               errors++;
               $display("FAIL bp_beat%0d got %0d/%h exp %0d/%h", n, dout_band, dout, n, saved[n]);
            end
            n++;
         end
         tick();
      end
      checks++;
      if (n != 8 || dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL bp_count got %0d valid %0b exp 8/0", n, dout_valid);
      end
   endtask

   task automatic test_overflow();
      logic [15:0] f [2][8];
      dout_ready = 1'b0;
      for (int j = 0; j < 3; j++) begin
         rand_bands();
         if (j < 2) f[j] = bv;
         cap(8'hFF);
      end
      checks++;
      if (frames_pending !== 2'd2 || overflow !== 1'b1 || drop_count !== 8'd1) begin
         errors++;
         $display("FAIL ovf_status got %0d/%0b/%0d exp 2/1/1", frames_pending, overflow, drop_count);
      end
      rand_bands();
      dout_ready = 1'b1;
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (dout_valid !== 1'b1 || dout_band !== 3'(i % 8) || dout !== f[i / 8][i % 8]) begin
            errors++;
            $display("FAIL ovf_beat%0d got %0b/%0d/%h exp 1/%0d/%h",
                     i, dout_valid, dout_band, dout, i % 8, f[i / 8][i % 8]);
         end
         tick();
      end
      checks++;
      if (dout_valid !== 1'b0 || frames_pending !== 2'd0) begin
         errors++;
         $display("FAIL ovf_end got valid %0b pend %0d exp 0/0", dout_valid, frames_pending);
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      dout_ready = 1'b0;
      rand_bands();
      cap(8'h01);
      rand_bands();
      cap(8'h03);
      checks++;
      if (frames_pending !== 2'd2 || dout_valid !== 1'b1 || dout_last !== 1'b1) begin
         errors++;
         $display("FAIL simul_pre got %0d/%0b/%0b exp 2/1/1", frames_pending, dout_valid, dout_last);
      end
      rand_bands();
      dout_ready = 1'b1;
      cap(8'hF0);
      checks++;
      if (frames_pending !== 2'd2 || overflow !== 1'b0 || drop_count !== 8'd0) begin
         errors++;
         $display("FAIL simul_post got %0d/%0b/%0d exp 2/0/0", frames_pending, overflow, drop_count);
      end
      checks++;
      if (dout_valid !== 1'b1 || dout_band !== 3'd0 || dout_last !== 1'b0) begin
         errors++;
         $display("FAIL simul_next got %0b/%0d/%0b exp 1/0/0", dout_valid, dout_band, dout_last);
      end
      for (int i = 0; i < 20 && frames_pending != 2'd0; i++) tick();
      checks++;
      if (frames_pending !== 2'd0 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL simul_drain got pend %0d left %0d exp 0/0", frames_pending, exp_q.size());
      end
   endtask

   task automatic test_mid_reset();
      dout_ready = 1'b1;
      rand_bands();
      cap(8'hFF);
      for (int i = 0; i < 4; i++) tick();
      checks++;
      if (dout_band !== 3'd3 || dout_valid !== 1'b1) begin
         errors++;
         $display("FAIL mid_pre got band %0d valid %0b exp 3/1", dout_band, dout_valid);
      end
      reset = 1'b1;
      capture = 1'b1;
      band_mask = 8'hFF;
      tick();
      reset = 1'b0;
      capture = 1'b0;
      checks++;
      if (dout !== 16'h0000 || dout_band !== 3'd0 || dout_last !== 1'b0 ||
          dout_valid !== 1'b0 || frames_pending !== 2'd0) begin
         errors++;
         $display("FAIL mid_reset got %h/%0d/%0b/%0b/%0d exp 0/0/0/0/0",
                  dout, dout_band, dout_last, dout_valid, frames_pending);
      end
      tick();
      checks++;
      if (dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_ignored got valid %0b exp 0", dout_valid);
      end
      rand_bands();
      cap(8'hFF);
      tick();
      checks++;
      if (dout_valid !== 1'b1 || dout_band !== 3'd0) begin
         errors++;
         $display("FAIL mid_restart got %0b/%0d exp 1/0", dout_valid, dout_band);
      end
      for (int i = 0; i < 12; i++) tick();
   endtask

   task automatic test_random();
      do_reset();
      for (int i = 0; i < 500; i++) begin
         rand_bands();
         dout_ready = ($urandom_range(3) != 0);
         capture = ($urandom_range(3) == 0);
         band_mask = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
         tick();
      end
      capture = 1'b0;
      dout_ready = 1'b1;
      for (int i = 0; i < 40 && (exp_q.size() != 0 || frames_pending != 2'd0); i++) tick();
      tick();
      checks++;
      if (exp_q.size() != 0 || dout_valid !== 1'b0) begin
         errors++;
         $display("FAIL rand_drain got left %0d valid %0b exp 0/0", exp_q.size(), dout_valid);
      end
   endtask

   initial begin
      for (int k = 0; k < 8; k++) bv[k] = '0;
      test_reset();
      test_single_frame();
      test_sparse();
      test_backpressure();
      test_overflow();
      test_simultaneous();
      test_mid_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
